uart_rx_buffered: RTL
=====================

// Module: uart_rx_buffered
// PURPOSE
//  Serial-line front end of the CPU's on-chip UART receive path; the host's serial_in feeds it.
//  - Deserialises 8N1 frames from the off-chip host and queues the received bytes in a FIFO.
//  - Presents bytes to the CPU memory-mapped I/O load path with a ready/valid handshake.
//  - Sits between the top-level serial_in pin and the CPU's UART MMIO register decode.
// PARAMETERS
//  CLOCK_FREQ  50_000_000  core clock frequency in Hz
//  BAUD_RATE   115_200     line rate in bit/s; SYMBOL_EDGE_TIME = CLOCK_FREQ/BAUD_RATE (truncating), must be >= 4
//  FIFO_DEPTH  8           received-byte queue depth; power of two, >= 2
// PORTS
//  clk             in   1                  core clock, all logic on rising edge
//  rst             in   1                  asynchronous, active-low reset (asserted at 0)
//  serial_in       in   1                  raw asynchronous line from host; idle high
//  data_out        out  8                  byte at FIFO head; 8'h00 when empty
//  data_out_valid  out  1                  FIFO non-empty
//  data_out_ready  in   1                  consumer pops head on valid && ready
//  fifo_count      out  $clog2(FIFO_DEPTH)+1  bytes currently queued
//  frame_error     out  1                  1-cycle pulse: stop bit sampled low
//  overrun         out  1                  1-cycle pulse: complete byte dropped because FIFO full
// BEHAVIOUR
//  Reset: all outputs 0, FIFO empty, FSM IDLE, synchroniser flops forced to 1, armed=0.
//  Input: 2-flop synchroniser on serial_in; all decisions use the synchronised line (2-cycle lag).
//  Arming: after reset, IDLE ignores a low line until the synchronised line has been 1 for >=1 cycle.
//    Purpose: a reset released mid-frame must not start on a data bit.
//  Bit counter: width $clog2(SYMBOL_EDGE_TIME); SAMPLE_TIME = SYMBOL_EDGE_TIME/2.
//  FSM:
//   IDLE  - armed && line==0 -> START, counter cleared.
//   START - at counter==SAMPLE_TIME: line==0 -> DATA (counter cleared); line==1 -> IDLE (glitch, no pulse).
//   DATA  - every SYMBOL_EDGE_TIME cycles, sample one bit, LSB first into shift register.
//           After the 8th bit -> STOP.
//   STOP  - after SYMBOL_EDGE_TIME cycles, sample (i.e. mid stop bit).
//           line==1: push byte to FIFO.
//           line==0: frame_error pulse, byte discarded.
//           Either way -> IDLE the same cycle, so back-to-back frames are accepted.
//  Push latency: data_out_valid rises the cycle after the stop-bit sample when the FIFO was empty.
//    fifo_count updates the same cycle.
//  Pop: on data_out_valid && data_out_ready, head advances next cycle.
//    ready while empty is ignored.
//  Full: push with FIFO full and no same-cycle pop -> overrun pulse; byte dropped, contents unchanged.
//  Simultaneous push+pop: always legal, including when full; count unchanged, order preserved.
//  Pointers wrap modulo FIFO_DEPTH; count distinguishes full from empty.
//  Reset mid-frame or with a non-empty FIFO: immediate return to reset state; queued bytes lost.
// STRUCTURE
//  Shared header uart_defs.vh:
//   - FSM state encodings (IDLE/START/DATA/STOP, 2 bits)
//   - UART_DATA_BITS=8
//   - macro for SYMBOL_EDGE_TIME. Reused by the transmitter.
//  Sub-module sync_fifo (WIDTH, DEPTH): ready/valid FIFO with count; this block instantiates one (WIDTH=8).
//  Top level holds synchroniser, arming flag, FSM, counters, shift register.
// TESTING (CLOCK_FREQ=50_000_000, BAUD_RATE=10_000_000 -> 5 cycles/bit, FIFO_DEPTH=8)
//  1. Send 8'h61, ready held 1.
//     -> one valid cycle with data_out=8'h61, no error/overrun pulses.
//  2. Send 8'h73,8'h77,8'h20 back-to-back, ready=0.
//     -> fifo_count=3; then raise ready: pops 73,77,20 on consecutive cycles, count 0.
//  3. 1-cycle low glitch (20 ns) on idle line.
//     -> returns to IDLE, no push, no frame_error, count stays 0.
//  4. Frame 8'h55 with stop bit driven 0.
//     -> frame_error pulses once, count unchanged; next good frame 8'h3e is received correctly.
//  5. Fill FIFO with 8 bytes 8'h30..8'h37, ready=0, send 8'h38.
//     -> overrun pulse, count=8, drain yields 30..37 in order.
//     Repeat with ready=1 timed to the stop-bit sample: 8'h38 accepted, no overrun.
//  6. Assert rst for 3 cycles mid-data-bit of a frame with 2 bytes queued.
//     -> count=0, valid=0 immediately.
//     Line held low for the remaining bits: no byte received until the line is seen high, then 8'h0d receives.

Source files
------------

// File: rtl/uart_rx_buffered_pkg.sv
// Shared definitions for the UART receive path: FSM state encoding, frame
// geometry and the symbol-time helper. The transmitter uses the same package.
package uart_rx_buffered_pkg;

    // Receiver / transmitter line states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_e;

    // 8N1 framing: eight data bits, LSB first.
    localparam int unsigned UART_DATA_BITS = 8;

    // Core clock cycles per bit on the line (truncating division).
    // Callers rely on the result being at least 4 so the mid-bit sample
    // point sits clearly inside the symbol.
    function automatic int unsigned symbol_edge_time(input int unsigned clock_freq,
                                                     input int unsigned baud_rate);
        return clock_freq / baud_rate;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock ready/valid FIFO with occupancy count. A write into a full
// queue is accepted only when the head is popped in the same cycle.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8    // power of two, >= 2
) (
    input  logic                     clk,
    input  logic                     rst,        // asynchronous, active low
    input  logic [WIDTH-1:0]         in_data_i,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    output logic [WIDTH-1:0]         out_data_o,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic             full, empty, push, pop;

    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);
    assign pop   = !empty && out_ready_i;
    // A full queue still takes a byte when the head leaves in the same cycle.
    assign in_ready_o = !full || out_ready_i;
    assign push  = in_valid_i && in_ready_o;

    assign out_valid_o = !empty;
    assign out_data_o  = empty ? '0 : mem_q[rd_ptr_q];
    assign count_o     = count_q;

    // Pointers wrap for free because DEPTH is a power of two; count tells full from empty.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            // NOTE: sequential state is updated with non-blocking assignments so every
            // flop sees the pre-edge values of the others, regardless of statement order.
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage array write port.
    // NOTE: the array is deliberately not reset; the pointers and count define which
    // entries are meaningful, and an unreset array maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= in_data_i;
    end

endmodule

// File: rtl/uart_rx_buffered.sv
// UART 8N1 receiver with a byte queue in front of the CPU MMIO load path.
// serial_in is synchronised, framed by a mid-bit sampling FSM and each good
// byte is pushed into a sync_fifo; framing errors and overruns are reported
// as single-cycle pulses.
module uart_rx_buffered
    import uart_rx_buffered_pkg::*;
#(
    parameter int unsigned CLOCK_FREQ = 50_000_000,
    parameter int unsigned BAUD_RATE  = 115_200,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,            // asynchronous, active low
    input  logic                          serial_in,
    output logic [7:0]                    data_out,
    output logic                          data_out_valid,
    input  logic                          data_out_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          frame_error,
    output logic                          overrun
);

    localparam int unsigned SYMBOL_EDGE_TIME = symbol_edge_time(CLOCK_FREQ, BAUD_RATE);
    localparam int unsigned SAMPLE_TIME      = SYMBOL_EDGE_TIME / 2;
    localparam int unsigned CNT_W            = $clog2(SYMBOL_EDGE_TIME);
    localparam int unsigned BIT_W            = $clog2(UART_DATA_BITS);

    localparam logic [CNT_W-1:0] SAMPLE_CNT = CNT_W'(SAMPLE_TIME);
    localparam logic [CNT_W-1:0] SYMBOL_CNT = CNT_W'(SYMBOL_EDGE_TIME - 1);
    localparam logic [BIT_W-1:0] LAST_BIT   = BIT_W'(UART_DATA_BITS - 1);

    // Synchroniser and arming
    logic       sync1_q, sync2_q;
    logic [1:0] sync_fill_q;
    logic       armed_q;
    logic       line;

    // Framing FSM and datapath
    uart_state_e               state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [BIT_W-1:0]          bit_q, bit_d;
    logic [UART_DATA_BITS-1:0] shift_q, shift_d;
    logic                      push;
    logic                      frame_error_d, frame_error_q;
    logic                      overrun_d, overrun_q;
    logic                      fifo_in_ready;

    assign line = sync2_q;

    // Two-flop synchroniser, plus arming: the line must be seen high before the first start bit.
    // The reset value of the synchroniser is forced high, so sync_fill_q tracks when a real
    // sample has reached sync2_q; arming on the forced value would let a reset released
    // mid-frame lock onto a data bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            sync_fill_q <= 2'b00;
            armed_q     <= 1'b0;
        end else begin
            sync1_q     <= serial_in;
            sync2_q     <= sync1_q;
            sync_fill_q <= {sync_fill_q[0], 1'b1};
            armed_q     <= armed_q | (sync_fill_q[1] & sync2_q);
        end
    end

    // FSM state, bit timer, bit index, shift register and status pulse registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            bit_q         <= '0;
            shift_q       <= '0;
            frame_error_q <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            bit_q         <= bit_d;
            shift_q       <= shift_d;
            frame_error_q <= frame_error_d;
            overrun_q     <= overrun_d;
        end
    end

    // Next-state logic: find the start edge, confirm it mid-bit, then sample each symbol centre.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves a
        // signal unassigned and no latch is inferred.
        state_d       = state_q;
        cnt_d         = cnt_q + 1'b1;
        bit_d         = bit_q;
        shift_d       = shift_q;
        push          = 1'b0;
        frame_error_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (armed_q && !line) state_d = ST_START;
            end
            ST_START: begin
                // Half a symbol in: still low means a real start bit, high means a glitch.
                if (cnt_q == SAMPLE_CNT) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = line ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (cnt_q == SYMBOL_CNT) begin
                    cnt_d   = '0;
                    shift_d = {line, shift_q[UART_DATA_BITS-1:1]};
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == LAST_BIT) state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                // Leave at mid stop bit so a start bit immediately following is not missed.
                if (cnt_q == SYMBOL_CNT) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                    if (line) push = 1'b1;
                    else      frame_error_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // A completed byte the queue cannot take is dropped and flagged.
    assign overrun_d = push && !fifo_in_ready;

    sync_fifo #(
        .WIDTH (UART_DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .in_data_i   (shift_q),
        .in_valid_i  (push),
        .in_ready_o  (fifo_in_ready),
        .out_data_o  (data_out),
        .out_valid_o (data_out_valid),
        .out_ready_i (data_out_ready),
        .count_o     (fifo_count)
    );

    assign frame_error = frame_error_q;
    assign overrun     = overrun_q;

endmodule
